sd_spi_phy: RTL and testbench

Byte-level SPI-mode master PHY for the SD card path, sitting directly downstream of `hazard3_sd`: the controller hands it one byte at a time, and it shifts the byte out on MOSI while shifting one byte in from MISO. It also drives SCK and CS_n. The PHY owns only bit timing and pin behaviour; command framing, CRC and response parsing stay in the controller.

---
 rtl/sd_spi_phy_if.sv | 24 ++
 rtl/sd_spi_phy.sv | 109 ++++++++++
 tb/tb_sd_spi_phy.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_phy_if.sv
// Controller-side byte handshake between hazard3_sd and the SPI-mode PHY.
// The controller drives the master modport, the PHY takes the slave modport.
interface sd_spi_phy_if #(
    parameter int DIV_W = 8
);
    logic [DIV_W-1:0] div;
    logic             cs_n_req;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             busy;

    modport master (
        output div, cs_n_req, tx_valid, tx_data,
        input  tx_ready, rx_valid, rx_data, busy
    );

    modport slave (
        input  div, cs_n_req, tx_valid, tx_data,
        output tx_ready, rx_valid, rx_data, busy
    );
endinterface

// File: rtl/sd_spi_phy.sv
// Byte-level SPI mode-0 master PHY for the SD card path: shifts one byte out on
// MOSI while shifting one in from MISO, and owns SCK timing and CS_n pin levels.
module sd_spi_phy #(
    parameter int DIV_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    sd_spi_phy_if.slave  ctl,
    output logic         sd_sck,
    output logic         sd_mosi,
    input  logic         sd_miso,
    output logic         sd_cs_n
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t           state_r;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] dl_r;
    logic [2:0]       bit_r;
    logic [7:0]       sh_r;
    logic             sd_sck_r;
    logic             sd_mosi_r;
    logic             sd_cs_n_r;
    logic             rx_valid_r;
    logic [7:0]       rx_data_r;
    logic             cnt_zero_s;

    assign cnt_zero_s   = (cnt_r == {DIV_W{1'b0}});
    assign ctl.tx_ready = (state_r == ST_IDLE);
    assign ctl.busy     = (state_r != ST_IDLE);
    assign ctl.rx_valid = rx_valid_r;
    assign ctl.rx_data  = rx_data_r;
    assign sd_sck       = sd_sck_r;
    assign sd_mosi      = sd_mosi_r;
    assign sd_cs_n      = sd_cs_n_r;

    // Bit-timing FSM: every pin and the receive result are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {DIV_W{1'b0}};
            dl_r       <= {DIV_W{1'b0}};
            bit_r      <= 3'd0;
            sh_r       <= 8'h00;
            sd_sck_r   <= 1'b0;
            sd_mosi_r  <= 1'b1;
            sd_cs_n_r  <= 1'b1;
            rx_valid_r <= 1'b0;
            rx_data_r  <= 8'h00;
        end else begin
            rx_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // CS only follows the request between bytes, never mid-byte.
                    sd_sck_r  <= 1'b0;
                    sd_cs_n_r <= ctl.cs_n_req;
                    if (ctl.tx_valid) begin
                        sh_r      <= ctl.tx_data;
                        sd_mosi_r <= ctl.tx_data[7];
                        dl_r      <= ctl.div;
                        cnt_r     <= ctl.div;
                        bit_r     <= 3'd0;
                        state_r   <= ST_LOW;
                    end else begin
                        sd_mosi_r <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (!cnt_zero_s) begin
                        cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
                    end else begin
                        // MISO is taken unsynchronized on the edge that raises SCK.
                        sd_sck_r <= 1'b1;
                        sh_r     <= {sh_r[6:0], sd_miso};
                        cnt_r    <= dl_r;
                        state_r  <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (!cnt_zero_s) begin
                        cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
                    end else begin
                        sd_sck_r <= 1'b0;
                        cnt_r    <= dl_r;
                        if (bit_r == 3'd7) begin
                            rx_data_r  <= sh_r;
                            rx_valid_r <= 1'b1;
                            sd_mosi_r  <= 1'b1;
                            state_r    <= ST_IDLE;
                        end else begin
                            bit_r     <= bit_r + 3'd1;
                            sd_mosi_r <= sh_r[7];
                            state_r   <= ST_LOW;
                        end
                    end
                end
                default: begin
                    sd_sck_r  <= 1'b0;
                    sd_mosi_r <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_spi_phy.sv
// Bench for sd_spi_phy: a timing-formula model of the pins and handshake is
// compared every cycle, and a literal table pins each received byte and its duration.
module tb_sd_spi_phy;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sd_sck, sd_mosi, sd_miso, sd_cs_n;

    always #5 clk = ~clk;

    sd_spi_phy_if #(.DIV_W(8)) ctl ();

    sd_spi_phy #(.DIV_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctl     (ctl),
        .sd_sck  (sd_sck),
        .sd_mosi (sd_mosi),
        .sd_miso (sd_miso),
        .sd_cs_n (sd_cs_n)
    );

    // Card model: presents the next bit after every SCK fall; else loopback.
    logic       use_card = 1'b0;
    logic       card_rst = 1'b0;
    logic [7:0] card_byte = 8'h00;
    logic [2:0] card_idx;

    always @(negedge sd_sck or posedge card_rst) begin
        if (card_rst) card_idx <= 3'd0;
        else          card_idx <= card_idx + 3'd1;
    end

    assign sd_miso = use_card ? card_byte[3'd7 - card_idx] : sd_mosi;

    logic [7:0] lit_rx  [9] = '{8'hA5, 8'h3C, 8'h40, 8'h00, 8'h95, 8'h5A, 8'h81, 8'h12, 8'h34};
    int         lit_len [9] = '{16, 64, 32, 32, 32, 16, 16, 48, 16};

    // Model state: byte in flight and cycles since its accept edge.
    logic       m_active = 1'b0;
    int         m_n = 0;
    int         m_dl = 0;
    logic [7:0] m_tx = 8'h00;
    logic [7:0] m_exp = 8'h00;
    logic [7:0] m_rxd = 8'h00;
    logic       m_rxv = 1'b0;
    logic       m_cs = 1'b1;
    int         m_li = 0;
    int         m_done = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_active = 1'b0; m_n = 0; m_rxv = 1'b0; m_rxd = 8'h00; m_cs = 1'b1;
            end else if (m_active) begin
                m_rxv = 1'b0;
                m_n = m_n + 1;
                if (m_n == 16 * (m_dl + 1)) begin
                    m_active = 1'b0; m_rxv = 1'b1; m_rxd = m_exp;
                    m_li = m_done; m_done = m_done + 1;
                end
            end else begin
                m_rxv = 1'b0;
                m_cs = ctl.cs_n_req;
                if (ctl.tx_valid) begin
                    m_active = 1'b1; m_n = 0; m_dl = int'(ctl.div);
                    m_tx = ctl.tx_data;
                    m_exp = use_card ? card_byte : ctl.tx_data;
                end
            end
        end
    end

    function automatic logic f_sck();
        if (!m_active) return 1'b0;
        return ((m_n / (m_dl + 1)) % 2) == 1;
    endfunction

    function automatic logic f_mosi();
        int b;
        if (!m_active) return 1'b1;
        b = 7 - m_n / (2 * (m_dl + 1));
        return m_tx[b];
    endfunction

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        else             n_pass = n_pass + 1;
    endtask

    // Compare process: sample on the falling clk edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_sck",      sd_sck,       32'd0);
                chk("rst_mosi",     sd_mosi,      32'd1);
                chk("rst_cs_n",     sd_cs_n,      32'd1);
                chk("rst_rx_valid", ctl.rx_valid, 32'd0);
                chk("rst_rx_data",  ctl.rx_data,  32'h00);
                chk("rst_tx_ready", ctl.tx_ready, 32'd1);
                chk("rst_busy",     ctl.busy,     32'd0);
            end else begin
                chk("sck",      sd_sck,       f_sck());
                chk("mosi",     sd_mosi,      f_mosi());
                chk("cs_n",     sd_cs_n,      m_cs);
                chk("tx_ready", ctl.tx_ready, !m_active);
                chk("busy",     ctl.busy,     m_active);
                chk("rx_valid", ctl.rx_valid, m_rxv);
                chk("rx_data",  ctl.rx_data,  m_rxd);
                if (m_rxv && (m_li < 9)) begin
                    chk("lit_rx_model", m_rxd,       lit_rx[m_li]);
                    chk("lit_rx_dut",   ctl.rx_data, lit_rx[m_li]);
                    chk("lit_len",      m_n,         lit_len[m_li]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] dv);
        @(posedge clk); #1;
        ctl.div = dv; ctl.tx_data = d; ctl.tx_valid = 1'b1;
        @(posedge clk); #1;
        ctl.tx_valid = 1'b0;
    endtask

    initial begin
        ctl.div = 8'd0; ctl.cs_n_req = 1'b1; ctl.tx_valid = 1'b0; ctl.tx_data = 8'h00;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Loopback 0xA5 at the fastest SCK.
        send(8'hA5, 8'd0);
        idle(20);

        // Card returns 0x3C while the PHY sends 0xFF, div=3.
        card_rst = 1'b1; #1; card_rst = 1'b0;
        card_byte = 8'h3C; use_card = 1'b1;
        send(8'hFF, 8'd3);
        idle(70);
        use_card = 1'b0;

        // Back-to-back with tx_valid held high, div=1.
        @(posedge clk); #1;
        ctl.div = 8'd1; ctl.tx_data = 8'h40; ctl.tx_valid = 1'b1;
        idle(1);
        ctl.tx_data = 8'h00;
        idle(33);
        ctl.tx_data = 8'h95;
        idle(33);
        ctl.tx_valid = 1'b0;
        idle(40);

        // CS asserted with the accept, deassert request raised mid-byte.
        @(posedge clk); #1;
        ctl.cs_n_req = 1'b0; ctl.div = 8'd0; ctl.tx_data = 8'h5A; ctl.tx_valid = 1'b1;
        idle(1);
        ctl.tx_valid = 1'b0;
        idle(5);
        ctl.cs_n_req = 1'b1;
        idle(20);

        // Reset at E0+5 aborts the byte; the next one completes.
        send(8'hC3, 8'd0);
        idle(4);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(3);
        send(8'h81, 8'd0);
        idle(20);

        // div change mid-byte only affects the following byte.
        send(8'h12, 8'd2);
        idle(10);
        ctl.div = 8'd0;
        idle(45);
        send(8'h34, 8'd0);
        idle(25);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
